// File: rtl/dsp_tiled_divider_unsigned.sv
// Multi-cycle unsigned restoring divider, BITS_PER_CYCLE quotient bits per cycle.
// Shares the valid / completing-next-cycle handshake with the tiled multiplier.
module dsp_tiled_divider_unsigned #(
  parameter int WIDTH          = 33,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_input,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_valid_output,
  output logic             o_completing_next_cycle,
  output logic             o_busy
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("dsp_tiled_divider_unsigned: illegal WIDTH/BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ITER, DONE_ZERO} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;   // top bit of the WIDTH+1 remainder is always 0 between steps
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH:0]   trial;

  assign last                    = (cnt == CW'(N - 1));
  assign o_completing_next_cycle = (state == ITER) && last;
  assign o_busy                  = (state != IDLE);

  // Unrolled restoring steps for one cycle
  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    trial   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      trial   = {rem_nxt, quo_nxt[WIDTH-1]};
      quo_nxt = quo_nxt << 1;
      if (trial >= {1'b0, dvs}) begin
        trial      = trial - {1'b0, dvs};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_valid_input) state_nxt = (i_divisor == '0) ? DONE_ZERO : ITER;
      ITER:      if (last) state_nxt = IDLE;
      DONE_ZERO: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      cnt            <= '0;
      o_quotient     <= '0;
      o_remainder    <= '0;
      o_div_by_zero  <= 1'b0;
      o_valid_output <= 1'b0;
    end else begin
      o_valid_output <= 1'b0;
      case (state)
        IDLE: if (i_valid_input) begin
          // dividend is held in quo for both paths; DONE_ZERO returns it as the remainder
          quo <= i_dividend;
          dvs <= i_divisor;
          rem <= '0;
          cnt <= '0;
        end
        ITER: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            o_quotient     <= quo_nxt;
            o_remainder    <= rem_nxt;
            o_div_by_zero  <= 1'b0;
            o_valid_output <= 1'b1;
          end
        end
        DONE_ZERO: begin
          o_quotient     <= '1;
          o_remainder    <= quo;
          o_div_by_zero  <= 1'b1;
          o_valid_output <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_tiled_divider_unsigned.sv
// Bench for dsp_tiled_divider_unsigned: directed cases plus random pairs on a
// WIDTH=33/BPC=1 and a WIDTH=32/BPC=4 instance, against plain / and % arithmetic.
module tb_dsp_tiled_divider_unsigned;
  logic        clk = 1'b0;
  logic        rst, v, sel;
  logic [63:0] a, b;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  logic [32:0] q33, r33;
  logic        dz33, ov33, cn33, bz33;
  logic [31:0] q4, r4;
  logic        dz4, ov4, cn4, bz4;

  dsp_tiled_divider_unsigned #(.WIDTH(33), .BITS_PER_CYCLE(1)) dut33 (
    .i_clk(clk), .i_rst(rst), .i_valid_input(v && !sel),
    .i_dividend(a[32:0]), .i_divisor(b[32:0]),
    .o_quotient(q33), .o_remainder(r33), .o_div_by_zero(dz33),
    .o_valid_output(ov33), .o_completing_next_cycle(cn33), .o_busy(bz33));

  dsp_tiled_divider_unsigned #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid_input(v && sel),
    .i_dividend(a[31:0]), .i_divisor(b[31:0]),
    .o_quotient(q4), .o_remainder(r4), .o_div_by_zero(dz4),
    .o_valid_output(ov4), .o_completing_next_cycle(cn4), .o_busy(bz4));

  logic [63:0] oq, orm;
  logic        odz, ov, ocn, obz;
  assign oq  = sel ? {32'b0, q4} : {31'b0, q33};
  assign orm = sel ? {32'b0, r4} : {31'b0, r33};
  assign odz = sel ? dz4 : dz33;
  assign ov  = sel ? ov4 : ov33;
  assign ocn = sel ? cn4 : cn33;
  assign obz = sel ? bz4 : bz33;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the operands are accepted at the following posedge.
  task automatic issue(input logic [63:0] x, input logic [63:0] y);
    a = x; b = y; v = 1'b1;
    @(posedge clk); #1 v = 1'b0;
  endtask

  // lat = number of posedges after the accepting edge before valid is seen.
  task automatic wait_done(input int poke_at, output int lat, output int cn_cnt,
                           output bit cn_before, output bit busy0);
    lat = 0; cn_cnt = 0; cn_before = 1'b0; busy0 = 1'b0;
    forever begin
      @(negedge clk);
      if (lat == 0) busy0 = obz;
      if (ov || lat > 200) break;
      if (lat == poke_at) begin a = 9; b = 3; v = 1'b1; end
      else v = 1'b0;
      cn_before = ocn;
      cn_cnt += int'(ocn);
      lat++;
    end
    v = 1'b0;
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask, eq, er;
    int n, elat, lat, cnc;
    bit cnb, bz0;
    mask = sel ? 64'hFFFF_FFFF : 64'h1_FFFF_FFFF;
    n    = sel ? 8 : 33;
    if (y == 0) begin eq = mask; er = x; elat = 1; end
    else begin eq = x / y; er = x % y; elat = n; end
    issue(x, y);
    wait_done(-1, lat, cnc, cnb, bz0);
    chk("latency", 64'(lat), 64'(elat));
    chk("quotient", oq, eq);
    chk("remainder", orm, er);
    chk("div_by_zero", {63'b0, odz}, {63'b0, y == 0});
    chk("busy_start", {63'b0, bz0}, 64'd1);
    chk("busy_at_valid", {63'b0, obz}, 64'd0);
    if (y == 0) chk("cnext_count", 64'(cnc), 64'd0);
    else begin
      chk("cnext_count", 64'(cnc), 64'd1);
      chk("cnext_before_valid", {63'b0, cnb}, 64'd1);
    end
  endtask

  function automatic logic [63:0] rnd_div(input logic [63:0] x, input logic [63:0] mask);
    case ($urandom_range(0, 4))
      0:       return 64'($urandom_range(0, 15));
      1:       return {$urandom, $urandom} & mask;
      2:       return (x >> $urandom_range(0, 31)) + 64'($urandom_range(0, 3));
      3:       return ($urandom_range(0, 3) == 0) ? 64'd0 : 64'd1;
      default: return 64'($urandom_range(1, 1000));
    endcase
  endfunction

  initial begin
    int lat, cnc, vcnt;
    bit cnb, bz0;
    logic [63:0] x, y, mask;
    rst = 1'b1; v = 1'b0; sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      chk("rst_quotient", oq, 64'd0);
      chk("rst_remainder", orm, 64'd0);
      chk("rst_flags", {60'b0, odz, ov, ocn, obz}, 64'd0);
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;

    run(100, 7);
    run(5, 0);
    run(64'h1_FFFF_FFFF, 1);
    run(3, 10);

    // 9/3 poked at E0+5 while busy must be dropped
    issue(1000, 3);
    wait_done(4, lat, cnc, cnb, bz0);
    chk("ignore_latency", 64'(lat), 64'd33);
    chk("ignore_quotient", oq, 64'd333);
    chk("ignore_remainder", orm, 64'd1);
    run(9, 3);  // issued in the valid cycle

    // reset sampled at E0+10 aborts the operation
    issue(1000, 3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", oq, 64'd0);
    chk("abort_remainder", orm, 64'd0);
    chk("abort_flags", {61'b0, odz, ov, obz}, 64'd0);
    vcnt = 0;
    repeat (40) begin @(negedge clk); vcnt += int'(ov); end
    chk("abort_no_valid", 64'(vcnt), 64'd0);
    run(50, 6);

    sel = 1'b1;
    @(negedge clk);
    run(64'hFFFF_FFFF, 64'h10);
    mask = 64'hFFFF_FFFF;
    for (int i = 0; i < 1500; i++) begin
      x = {$urandom, $urandom} & mask;
      y = rnd_div(x, mask) & mask;
      run(x, y);
    end
    sel = 1'b0;
    @(negedge clk);
    mask = 64'h1_FFFF_FFFF;
    for (int i = 0; i < 400; i++) begin
      x = {$urandom, $urandom} & mask;
      y = rnd_div(x, mask) & mask;
      run(x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
